// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg -- shared opcode/state encodings and BCD constants for cpu_alu_seq.
// Rev 1.0
`default_nettype none

package cpu_alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADC   = 4'h1,
    OP_SBC   = 4'h2,
    OP_AND   = 4'h3,
    OP_ORA   = 4'h4,
    OP_EOR   = 4'h5,
    OP_CMP   = 4'h6,
    OP_ASL   = 4'h7,
    OP_LSR   = 4'h8,
    OP_ROL   = 4'h9,
    OP_ROR   = 4'hA,
    OP_INC   = 4'hB,
    OP_DEC   = 4'hC,
    OP_BIT   = 4'hD,
    OP_RSV_E = 4'hE,
    OP_RSV_F = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADJ  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam logic [3:0] BCD_FIX = 4'd6;
  localparam logic [4:0] BCD_MAX = 5'd9;

endpackage

`default_nettype wire

// File: rtl/cpu_alu_bcd_adj.sv
// cpu_alu_bcd_adj -- combinational packed-BCD add/subtract with per-digit correction.
// Rev 1.0
`default_nettype none

module cpu_alu_bcd_adj
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             is_sbc,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int DIGITS = WIDTH / 4;

  // Digit chain carries a carry for ADC and a borrow for SBC.
  logic [DIGITS:0] chain;

  assign chain[0] = is_sbc ? ~carry_in : carry_in;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] da;
    logic [3:0] db;
    logic [4:0] raw_add;
    logic [4:0] raw_sub;
    logic       add_fix;
    logic       sub_fix;

    assign da      = a[4*i +: 4];
    assign db      = b[4*i +: 4];
    assign raw_add = {1'b0, da} + {1'b0, db} + {4'b0000, chain[i]};
    assign raw_sub = {1'b0, da} - {1'b0, db} - {4'b0000, chain[i]};
    assign add_fix = (raw_add > BCD_MAX);
    assign sub_fix = raw_sub[4];

    assign result[4*i +: 4] = is_sbc ? (raw_sub[3:0] - (sub_fix ? BCD_FIX : 4'd0))
                                     : (raw_add[3:0] + (add_fix ? BCD_FIX : 4'd0));
    assign chain[i+1]       = is_sbc ? sub_fix : add_fix;
  end

  assign carry_out = is_sbc ? ~chain[DIGITS] : chain[DIGITS];

endmodule

`default_nettype wire

// File: rtl/cpu_alu_seq.sv
// cpu_alu_seq -- registered 6502-style ALU with valid/ready handshake and decimal ADC/SBC.
// Rev 1.0
`default_nettype none

module cpu_alu_seq
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit DECIMAL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in,
  input  logic             decimal_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             overflow_flag
);

  localparam int MSB = WIDTH - 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             cin_q, cin_d;
  logic             sub_q, sub_d;
  logic             vbin_q, vbin_d;

  alu_op_e          op;
  logic             take;
  logic             dec_mode;
  logic             sub_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH-1:0] bin_res;
  logic             bin_c, bin_z, bin_n, bin_v;
  logic [WIDTH-1:0] bcd_res;
  logic             bcd_c;

  assign op       = alu_op_e'(alu_op);
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign take     = in_valid && in_ready;
  assign dec_mode = DECIMAL_EN && decimal_in && ((op == OP_ADC) || (op == OP_SBC));

  // CMP always subtracts without borrow; SBC uses carry_in as the inverted borrow.
  assign sub_cin = (op == OP_CMP) ? 1'b1 : carry_in;
  assign add_sum = {1'b0, operand_a} + {1'b0, operand_b} + {{WIDTH{1'b0}}, carry_in};
  assign sub_sum = {1'b0, operand_a} + {1'b0, ~operand_b} + {{WIDTH{1'b0}}, sub_cin};

  always_comb begin
    bin_res = operand_a;
    bin_c   = carry_in;
    bin_v   = 1'b0;
    case (op)
      OP_ADC: begin
        bin_res = add_sum[MSB:0];
        bin_c   = add_sum[WIDTH];
        bin_v   = (operand_a[MSB] == operand_b[MSB]) && (add_sum[MSB] != operand_a[MSB]);
      end
      OP_SBC: begin
        bin_res = sub_sum[MSB:0];
        bin_c   = sub_sum[WIDTH];
        bin_v   = (operand_a[MSB] != operand_b[MSB]) && (sub_sum[MSB] != operand_a[MSB]);
      end
      OP_AND: bin_res = operand_a & operand_b;
      OP_ORA: bin_res = operand_a | operand_b;
      OP_EOR: bin_res = operand_a ^ operand_b;
      OP_CMP: bin_c = sub_sum[WIDTH];
      OP_ASL: begin
        bin_res = {operand_a[MSB-1:0], 1'b0};
        bin_c   = operand_a[MSB];
      end
      OP_LSR: begin
        bin_res = {1'b0, operand_a[MSB:1]};
        bin_c   = operand_a[0];
      end
      OP_ROL: begin
        bin_res = {operand_a[MSB-1:0], carry_in};
        bin_c   = operand_a[MSB];
      end
      OP_ROR: begin
        bin_res = {carry_in, operand_a[MSB:1]};
        bin_c   = operand_a[0];
      end
      OP_INC: bin_res = operand_a + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_DEC: bin_res = operand_a - {{(WIDTH-1){1'b0}}, 1'b1};
      OP_BIT: bin_v = operand_b[MSB-1];
      default: ;
    endcase
    bin_z = (bin_res == '0);
    bin_n = bin_res[MSB];
    if (op == OP_CMP) begin
      bin_z = (operand_a == operand_b);
      bin_n = sub_sum[MSB];
    end
    if (op == OP_BIT) begin
      bin_z = ((operand_a & operand_b) == '0);
      bin_n = operand_b[MSB];
    end
  end

  cpu_alu_bcd_adj #(
    .WIDTH (WIDTH)
  ) u_bcd_adj (
    .a         (opa_q),
    .b         (opb_q),
    .carry_in  (cin_q),
    .is_sbc    (sub_q),
    .result    (bcd_res),
    .carry_out (bcd_c)
  );

  // Output registers are only written once the final value is known, so a
  // decimal op leaves them untouched until ADJ.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cin_d    = cin_q;
    sub_d    = sub_q;
    vbin_d   = vbin_q;
    case (state_q)
      ST_IDLE: ;
      ST_ADJ: begin
        result_d = bcd_res;
        carry_d  = bcd_c;
        zero_d   = (bcd_res == '0);
        neg_d    = bcd_res[MSB];
        ovf_d    = vbin_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready && !in_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      opa_d = operand_a;
      opb_d = operand_b;
      cin_d = carry_in;
      sub_d = (op == OP_SBC);
      if (dec_mode) begin
        vbin_d  = bin_v;
        state_d = ST_ADJ;
      end else begin
        result_d = bin_res;
        carry_d  = bin_c;
        zero_d   = bin_z;
        neg_d    = bin_n;
        ovf_d    = bin_v;
        state_d  = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      sub_q    <= 1'b0;
      vbin_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cin_q    <= cin_d;
      sub_q    <= sub_d;
      vbin_q   <= vbin_d;
    end
  end

  assign out_valid     = (state_q == ST_DONE);
  assign result        = result_q;
  assign carry_out     = carry_q;
  assign zero_flag     = zero_q;
  assign negative_flag = neg_q;
  assign overflow_flag = ovf_q;

endmodule

`default_nettype wire

// File: doc/cpu_alu_seq.md
# cpu_alu_seq

Registered, parametrised successor to the 6502 combinational ALU. It accepts operations over a valid/ready handshake and supports any operand width that is a multiple of 4. It adds 65C02-style decimal (BCD) ADC/SBC through an extra correction cycle. It sits between the CPU execute stage and the register file and holds its result until the consumer accepts it.

## Interface
- `WIDTH`, default 8: operand/result width; multiple of 4, minimum 8.
- `DECIMAL_EN`, default 1: when 0, `decimal_in` is ignored and the ADJ state is never entered.

Ports:
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  block can accept a request.
- `alu_op`  input  4  operation code (`alu_op_e`).
- `operand_a`  input  WIDTH  first operand.
- `operand_b`  input  WIDTH  second operand.
- `carry_in`  input  1  C flag in.
- `decimal_in`  input  1  D flag; applies to ADC/SBC only.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts the result.
- `result`  output  WIDTH  registered result.
- `carry_out`, `zero_flag`, `negative_flag`, `overflow_flag`  output  1 each  registered flags.

## Operation
- Opcodes:
  - 0 NOP, 1 ADC, 2 SBC, 3 AND, 4 ORA, 5 EOR, 6 CMP, 7 ASL, 8 LSR, 9 ROL, A ROR, B INC, C DEC, D BIT.
  - E and F behave as NOP.
- Binary semantics per op, with MSB = bit WIDTH-1:
  - ADC/SBC: C is the carry / inverted borrow out of MSB; V is signed overflow; N is the MSB.
  - AND/ORA/EOR: C passes through unchanged; V=0.
  - CMP: result = a; C = (a ≥ b) unsigned; Z = (a == b); N = MSB of (a−b); V=0.
  - Shifts/rotates: C is the bit shifted out; ROL/ROR rotate through `carry_in`.
  - INC/DEC: wrap modulo 2^WIDTH; C passes through unchanged.
  - BIT: result = a; Z = ((a & b) == 0); N = b[MSB]; V = b[MSB−1].
  - NOP: result = a; Z and N are computed from a; C passes through; V=0.
  - In every op, Z is computed from the result unless stated otherwise.
- Decimal mode applies when `decimal_in` && `DECIMAL_EN` && op is ADC or SBC:
  - Operands are treated as WIDTH/4 packed BCD digits.
  - ADC: each digit sum greater than 9 gets +6 and carries into the next digit.
  - SBC: a digit that borrows gets −6 and borrows from the next digit.
  - C is the decimal carry (ADC) or inverted decimal borrow (SBC).
  - N and Z are computed from the final decimal result.
  - V is taken from the binary computation.
  - Invalid BCD digits produce no defined value, but must never hang the FSM.
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid` is high, latch the inputs and compute the binary result. Go to ADJ if in decimal mode, else to DONE.
  - ADJ: apply the decimal correction from the latched operands, then go to DONE.
  - DONE: `out_valid`=1. Outputs are held stable while `out_ready`=0. When `out_ready`=1: if `in_valid` is also high, accept the new request in the same cycle (back-to-back operation, same transitions as IDLE); otherwise go to IDLE.
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`). It is combinational; `out_ready` → `in_ready` is the only combinational path.
- Reset mid-operation: abort immediately and return to IDLE; no result is produced.

## Timing
- Reset values: state IDLE; `result`=0; all flags 0; `out_valid`=0; `in_ready`=1.
- Binary op: accepted at edge N, `out_valid` high after edge N+1; latency 1.
- Decimal op: `out_valid` high after edge N+2; latency 2.
- Throughput:
  - Binary: one result per cycle while `out_ready`=1.
  - Decimal: one result per 2 cycles.
- `result` and all flags are registered and change only when a new result is registered.
- While `out_valid`=1 and `out_ready`=0, `result` and flags are bit-stable.

## Structure
- Package `cpu_alu_pkg` holds:
  - `alu_op_e` (4-bit enum; the encoding above; shared with the decoder).
  - `alu_state_e` (IDLE/ADJ/DONE).
  - The BCD correction constants (6, 9).
- Sub-module `cpu_alu_bcd_adj`: combinational, parametrised by `WIDTH`. Inputs are a, b, carry_in and the ADC/SBC select; outputs are the decimal result and decimal carry. It is instantiated once and used in ADJ.

## Test plan
- Binary ADC, WIDTH=8: 0x50 + 0x50, carry_in=0 → result 0xA0, C=0, V=1, N=1, Z=0; `out_valid` 1 cycle after accept.
- Decimal ADC, WIDTH=8: 0x58 + 0x46, carry_in=1 → result 0x05, C=1, Z=0; latency 2 cycles.
- Decimal SBC, WIDTH=8: 0x12 − 0x21, carry_in=1 → result 0x91, C=0, N=1.
- Backpressure: CMP 0x40 vs 0x40 with `out_ready`=0 for 3 cycles → Z=1, C=1 held stable; `in_ready`=0 throughout. Raising `out_ready` with `in_valid`=1 accepts the next op in the same cycle.
- WIDTH=16, decimal ADC: 0x9999 + 0x0001, carry_in=0 → result 0x0000, C=1, Z=1.
- Reset asserted while in ADJ → all outputs return to their reset values immediately; after release, `in_ready`=1 and `out_valid`=0.
